ysyx_25020047_lsu: RTL



---
 rtl/ysyx_25020047_pkg.sv | 22 ++
 rtl/ysyx_25020047_lsu_if.sv | 29 ++
 rtl/ysyx_25020047_lsu_align.sv | 35 +++
 rtl/ysyx_25020047_lsu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 load/store unit:
// access-size encodings, LSU FSM states and byte-strobe constants.
package ysyx_25020047_pkg;

  // Access size encodings (value 1 is reserved for halfword support).
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte strobe constants for a 32-bit data bus.
  localparam logic [3:0] WMASK_NONE  = 4'h0;
  localparam logic [3:0] WMASK_BYTE0 = 4'h1;
  localparam logic [3:0] WMASK_WORD  = 4'hF;

  // One memory transaction per instruction: accept, request, wait, deliver.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25020047_lsu_if.sv
// Valid/ready memory bus between the LSU (master) and the memory side (slave).
// Request channel carries a word-aligned address, write flag, lane data and
// byte strobes; response channel returns read data and an error flag.
interface ysyx_25020047_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic for the LSU: store data replication and byte
// strobes on the way out, byte extraction with zero extension on the way in.
// Kept separate so halfword variants can be added in one place.
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        write_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wmask_o,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  // Select lanes by access size; any non-byte size is handled as a full word.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    st_wdata_o = st_data_i;
    st_wmask_o = WMASK_NONE;
    ld_data_o  = ld_rdata_i;
    if (size_i == SZ_BYTE) begin
      st_wdata_o = {4{st_data_i[7:0]}};
      ld_data_o  = {24'd0, ld_rdata_i[8*addr_lo_i +: 8]};
      if (write_i) begin
        st_wmask_o = WMASK_BYTE0 << addr_lo_i;
      end
    end else if (write_i) begin
      st_wmask_o = WMASK_WORD;
    end
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit behind the execute stage. Accepts one instruction at a
// time, issues at most one bus transaction, and hands the result to
// writeback. Non-memory instructions pass their ALU result straight through.
// Optional build macro YSYX_25020047_LSU_MISALIGN_CHECK_EN: when defined, a
// word access with a non-zero low address pair faults without touching the bus.
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ADDR_W-1:0]   in_addr_i,
  input  logic [DATA_W-1:0]   in_wdata_i,
  input  logic                in_read_i,
  input  logic                in_write_i,
  input  logic [1:0]          in_size_i,
  input  logic [4:0]          in_rd_i,
  input  logic                in_reg_wen_i,
  ysyx_25020047_lsu_if.master mem,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [4:0]          out_rd_o,
  output logic                out_reg_wen_o,
  output logic                out_err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic [4:0]          rd_q, rd_d;
  logic                reg_wen_q, reg_wen_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                misalign;
  logic                timeout_hit;
  logic                req_valid;
  logic                done;
  logic [DATA_W-1:0]   st_wdata;
  logic [3:0]          st_wmask;
  logic [DATA_W-1:0]   ld_data;

`ifdef YSYX_25020047_LSU_MISALIGN_CHECK_EN
  assign misalign = (in_size_i == SZ_WORD) && (in_addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // The last counted WAIT cycle; a response in the same cycle still wins.
  assign timeout_hit = (cnt_q >= CNT_LAST);

  ysyx_25020047_lsu_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .write_i    (write_q),
    .st_data_i  (wdata_q),
    .st_wdata_o (st_wdata),
    .st_wmask_o (st_wmask),
    .ld_rdata_i (mem.resp_rdata),
    .ld_data_o  (ld_data)
  );

  // Next-state and datapath capture for the accept/request/wait/deliver FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    size_d    = size_q;
    rd_d      = rd_q;
    reg_wen_d = reg_wen_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          addr_d    = in_addr_i;
          wdata_d   = in_wdata_i;
          read_d    = in_read_i;
          write_d   = in_write_i;
          size_d    = in_size_i;
          rd_d      = in_rd_i;
          reg_wen_d = in_reg_wen_i;
          data_d    = '0;
          err_d     = 1'b0;
          if (in_read_i && in_write_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (!in_read_i && !in_write_i) begin
            data_d  = DATA_W'(in_addr_i);
            state_d = DONE;
          end else if (misalign) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.resp_valid) begin
          data_d  = read_q ? ld_data : '0;
          err_d   = mem.resp_err;
          state_d = DONE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      size_q    <= SZ_BYTE;
      rd_q      <= '0;
      reg_wen_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      size_q    <= size_d;
      rd_q      <= rd_d;
      reg_wen_q <= reg_wen_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Request fields come from latched values, so they hold while stalled.
  assign req_valid     = (state_q == REQ);
  assign mem.req_valid = req_valid;
  assign mem.req_addr  = req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.req_wen   = req_valid & write_q;
  assign mem.req_wdata = req_valid ? st_wdata : '0;
  assign mem.req_wmask = req_valid ? st_wmask : WMASK_NONE;

  // Writeback side: faults and stores never write a register.
  assign done          = (state_q == DONE);
  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = done;
  assign out_data_o    = done ? data_q : '0;
  assign out_err_o     = done & err_q;
  assign out_reg_wen_o = done & reg_wen_q & ~write_q & ~err_q;
  assign out_rd_o      = out_reg_wen_o ? rd_q : '0;

endmodule
